// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: retires K multiplier bits per clock into a 2W-bit
// product register, with start/busy/done handshake and a held result register z.
module seq_multiplier #(
  parameter int W = 32,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);

  localparam int N  = W / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] p_p0;
  logic [2*W-1:0] p_nxt;
  logic [W-1:0]   y_p0;
  logic           s_p0;
  logic           last;

  // One multiplier bit: W+1-bit accumulate (sign-extended or carry-extended), then shift right.
  function automatic logic [2*W-1:0] shift_add_step(input logic [2*W-1:0] p,
                                                    input logic [W-1:0]   yv,
                                                    input logic           s,
                                                    input logic           sub);
    logic [W:0] hi;
    logic [W:0] ad;
    logic [W:0] acc;
    hi  = s ? {p[2*W-1], p[2*W-1:W]} : {1'b0, p[2*W-1:W]};
    ad  = p[0] ? (s ? {yv[W-1], yv} : {1'b0, yv}) : '0;
    acc = sub ? (hi - ad) : (hi + ad);
    return {acc, p[W-1:1]};
  endfunction

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Stage p0 -> next: K chained steps; the very last step of a signed op subtracts
  always_comb begin
    p_nxt = p_p0;
    for (int i = 0; i < K; i++) begin
      p_nxt = shift_add_step(p_nxt, y_p0, s_p0, s_p0 && last && (i == K - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      z     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            z     <= p_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand/product datapath registers carry no reset; they are always loaded on start.
  always_ff @(posedge clk) begin
    if ((state != RUN) && start) begin
      p_p0 <= {{W{1'b0}}, x};
      y_p0 <= y;
      s_p0 <= sgn;
    end else if (state == RUN) begin
      p_p0 <= p_nxt;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: W=32 with K=1 and K=2, and W=8 with K=1,2,4 in parallel.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        sa, sga, busya, donea;
  logic [31:0] xa, ya;
  logic [63:0] za;
  logic        sb, sgb, busyb, doneb;
  logic [31:0] xb, yb;
  logic [63:0] zb;
  logic        s8, sg8;
  logic [7:0]  x8, y8;
  logic        busy81, done81, busy82, done82, busy84, done84;
  logic [15:0] z81, z82, z84;

  seq_multiplier #(.W(32), .K(1)) u_a (.clk(clk), .rst(rst), .start(sa), .sgn(sga), .x(xa), .y(ya),
                                      .busy(busya), .done(donea), .z(za));
  seq_multiplier #(.W(32), .K(2)) u_b (.clk(clk), .rst(rst), .start(sb), .sgn(sgb), .x(xb), .y(yb),
                                      .busy(busyb), .done(doneb), .z(zb));
  seq_multiplier #(.W(8), .K(1)) u_81 (.clk(clk), .rst(rst), .start(s8), .sgn(sg8), .x(x8), .y(y8),
                                      .busy(busy81), .done(done81), .z(z81));
  seq_multiplier #(.W(8), .K(2)) u_82 (.clk(clk), .rst(rst), .start(s8), .sgn(sg8), .x(x8), .y(y8),
                                      .busy(busy82), .done(done82), .z(z82));
  seq_multiplier #(.W(8), .K(4)) u_84 (.clk(clk), .rst(rst), .start(s8), .sgn(sg8), .x(x8), .y(y8),
                                      .busy(busy84), .done(done84), .z(z84));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op on u_a and wait (bounded) for done; edges counted from the start edge.
  task automatic run_a(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [63:0] z, output int runc, output int edges, output bit got);
    xa = x; ya = y; sga = s; sa = 1'b1;
    tick;
    sa = 1'b0;
    runc = 0; edges = 0;
    while (!donea && edges < 200) begin
      if (busya) runc++;
      tick;
      edges++;
    end
    got = donea;
    z   = za;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sa = 0; sga = 0; xa = 0; ya = 0;
    sb = 0; sgb = 0; xb = 0; yb = 0;
    s8 = 0; sg8 = 0; x8 = 0; y8 = 0;
    tick; tick;
    n_cmp++;
    if ({busya, donea, busyb, doneb} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busya, donea, busyb, doneb});
    end
    n_cmp++;
    if (za !== 64'h0 || zb !== 64'h0) begin
      n_fail++; $display("FAIL reset_z: got %h/%h expected 0", za, zb);
    end
    n_cmp++;
    if ({busy81, done81, busy82, done82, busy84, done84} !== 6'b0 || z81 !== 16'h0) begin
      n_fail++; $display("FAIL reset_w8: ctrl %b z %h expected 0", {busy81, done81, busy82, done82, busy84, done84}, z81);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [63:0] z; int runc, edges; bit got; int extra_done;
    run_a(32'd7, 32'd6, 1'b0, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'h2A) begin
      n_fail++; $display("FAIL basic_z: got %h (done=%0d) expected 2a", z, got);
    end
    n_cmp++;
    if (runc !== 32 || edges !== 32) begin
      n_fail++; $display("FAIL basic_latency: busy %0d edges %0d expected 32/32", runc, edges);
    end
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (donea) extra_done++;
    end
    n_cmp++;
    if (za !== 64'h2A || extra_done !== 0) begin
      n_fail++; $display("FAIL basic_hold: z %h extra done %0d expected 2a/0", za, extra_done);
    end
  endtask

  task automatic test_extremes;
    logic [63:0] z; int runc, edges; bit got;
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL umax: got %h expected fffffffe00000001", z);
    end
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'h1) begin
      n_fail++; $display("FAIL sneg1: got %h expected 1", z);
    end
    run_a(32'h8000_0000, 32'h8000_0000, 1'b1, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'h4000_0000_0000_0000) begin
      n_fail++; $display("FAIL smin_sq: got %h expected 4000000000000000", z);
    end
    run_a(32'h8000_0000, 32'h0000_0001, 1'b1, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++; $display("FAIL smin_x1: got %h expected ffffffff80000000", z);
    end
    run_a(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, z, runc, edges, got);
    n_cmp++;
    if (!got || z !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_fail++; $display("FAIL sneg2_x3: got %h expected fffffffffffffffa", z);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    xb = 32'h1234_5678; yb = 32'h9ABC_DEF0; sgb = 1'b0; sb = 1'b1;
    tick;
    edges = 0;
    while (!doneb && edges < 100) begin tick; edges++; end
    n_cmp++;
    if (!doneb || edges !== 16) begin
      n_fail++; $display("FAIL k2_latency: edges %0d (done=%0d) expected 16", edges, doneb);
    end
    n_cmp++;
    if (zb !== 64'h0B00_EA4E_242D_2080) begin
      n_fail++; $display("FAIL k2_z: got %h expected 0b00ea4e242d2080", zb);
    end
    xb = 32'd3; yb = 32'd5;
    tick;
    sb = 1'b0;
    n_cmp++;
    if (busyb !== 1'b1 || doneb !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart: busy %b done %b expected 1/0", busyb, doneb);
    end
    n_cmp++;
    if (zb !== 64'h0B00_EA4E_242D_2080) begin
      n_fail++; $display("FAIL b2b_hold: got %h expected 0b00ea4e242d2080", zb);
    end
    edges = 0;
    while (!doneb && edges < 100) begin tick; edges++; end
    n_cmp++;
    if (!doneb || edges !== 16 || zb !== 64'd15) begin
      n_fail++; $display("FAIL b2b_second: z %h edges %0d expected f/16", zb, edges);
    end
    tick;
  endtask

  task automatic test_start_ignored;
    int dones;
    xa = 32'd7; ya = 32'd6; sga = 1'b0; sa = 1'b1;
    tick;
    sa = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    xa = 32'd99; ya = 32'd99; sa = 1'b1;
    tick;
    sa = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (donea) dones++;
      tick;
    end
    n_cmp++;
    if (dones !== 1 || za !== 64'h2A) begin
      n_fail++; $display("FAIL start_ignored: dones %0d z %h expected 1/2a", dones, za);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    xa = 32'd5; ya = 32'd9; sga = 1'b0; sa = 1'b1;
    tick;
    sa = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    n_cmp++;
    if (busya !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: busy %b expected 1", busya);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busya !== 1'b0 || donea !== 1'b0 || za !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_async: busy %b done %b z %h expected 0/0/0", busya, donea, za);
    end
    #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (donea || busya) dones++;
    end
    n_cmp++;
    if (dones !== 0 || za !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_after: activity %0d z %h expected 0/0", dones, za);
    end
  endtask

  task automatic test_w8_sweep;
    logic [7:0] vals [16];
    logic [15:0] ref_p, g1, g2, g4;
    int e, e1, e2, e4;
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFE,
             8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h40, 8'hC0, 8'h6B};
    for (int sm = 0; sm < 2; sm++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          x8 = vals[i]; y8 = vals[j]; sg8 = sm[0]; s8 = 1'b1;
          if (sm == 1) ref_p = 16'($signed({{8{x8[7]}}, x8}) * $signed({{8{y8[7]}}, y8}));
          else         ref_p = 16'({8'h00, x8} * {8'h00, y8});
          tick;
          s8 = 1'b0;
          e = 0; e1 = -1; e2 = -1; e4 = -1; g1 = 'x; g2 = 'x; g4 = 'x;
          while ((e1 < 0 || e2 < 0 || e4 < 0) && e < 20) begin
            tick;
            e++;
            if (done81 && e1 < 0) begin e1 = e; g1 = z81; end
            if (done82 && e2 < 0) begin e2 = e; g2 = z82; end
            if (done84 && e4 < 0) begin e4 = e; g4 = z84; end
          end
          n_cmp++;
          if (g1 !== ref_p || e1 !== 8) begin
            n_fail++; $display("FAIL w8k1 %h*%h s%0d: z %h lat %0d expected %h/8", x8, y8, sm, g1, e1, ref_p);
          end
          n_cmp++;
          if (g2 !== ref_p || e2 !== 4) begin
            n_fail++; $display("FAIL w8k2 %h*%h s%0d: z %h lat %0d expected %h/4", x8, y8, sm, g2, e2, ref_p);
          end
          n_cmp++;
          if (g4 !== ref_p || e4 !== 2) begin
            n_fail++; $display("FAIL w8k4 %h*%h s%0d: z %h lat %0d expected %h/2", x8, y8, sm, g4, e4, ref_p);
          end
          tick;
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    test_w8_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
